// File: rtl/and2_seq_ctrl_if.sv
// Control/gate bundle between a BIST controller and and2_seq_ctrl.
// The first-error log fields exist only when AND2_SEQ_ERRLOG_EN is defined.
interface and2_seq_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             gate_out;
    logic             drv_a;
    logic             drv_b;
    logic [1:0]       vec_idx;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic             pass;
`ifdef AND2_SEQ_ERRLOG_EN
    logic             first_err_vld;
    logic [1:0]       first_err_idx;

    modport master (
        output start, gate_out,
        input  drv_a, drv_b, vec_idx, busy, done, err_cnt, pass,
        input  first_err_vld, first_err_idx
    );
    modport slave (
        input  start, gate_out,
        output drv_a, drv_b, vec_idx, busy, done, err_cnt, pass,
        output first_err_vld, first_err_idx
    );
`else
    modport master (
        output start, gate_out,
        input  drv_a, drv_b, vec_idx, busy, done, err_cnt, pass
    );
    modport slave (
        input  start, gate_out,
        output drv_a, drv_b, vec_idx, busy, done, err_cnt, pass
    );
`endif
endinterface

// File: rtl/and2_seq_ctrl.sv
// Clocked Gray-order exerciser for an and2 cell: drives 00,10,11,01, samples, counts mismatches.
// Optional first-error log enabled by defining AND2_SEQ_ERRLOG_EN.
module and2_seq_ctrl #(
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    and2_seq_ctrl_if.slave sif
);
    localparam int TMR_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       vec_q, vec_d;
    logic             drv_a_q, drv_a_d;
    logic             drv_b_q, drv_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             mismatch;
`ifdef AND2_SEQ_ERRLOG_EN
    logic             fev_q, fev_d;
    logic [1:0]       fei_q, fei_d;
`endif

    // {a,b} for each vector index; one input toggles per step.
    function automatic logic [1:0] gray_ab(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // Case-inequality so an undriven or X gate output is flagged, not masked.
    assign mismatch = (sif.gate_out !== (drv_a_q & drv_b_q));

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        vec_d   = vec_q;
        drv_a_d = drv_a_q;
        drv_b_d = drv_b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        pass_d  = pass_q;
`ifdef AND2_SEQ_ERRLOG_EN
        fev_d   = fev_q;
        fei_d   = fei_q;
`endif
        case (state_q)
            IDLE: begin
                if (sif.start) begin
                    state_d            = SETTLE;
                    tmr_d              = '0;
                    vec_d              = 2'd0;
                    {drv_a_d, drv_b_d} = 2'b00;
                    busy_d             = 1'b1;
                    err_d              = '0;
                    pass_d             = 1'b0;
`ifdef AND2_SEQ_ERRLOG_EN
                    fev_d              = 1'b0;
                    fei_d              = 2'd0;
`endif
                end
            end
            SETTLE: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TMR_LAST) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_q != CNT_MAX) err_d = err_q + 1'b1;
`ifdef AND2_SEQ_ERRLOG_EN
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fei_d = vec_q;
                    end
`endif
                end
                if (vec_q != 2'd3) begin
                    vec_d              = vec_q + 2'd1;
                    {drv_a_d, drv_b_d} = gray_ab(vec_d);
                    tmr_d              = '0;
                    state_d            = SETTLE;
                end else begin
                    // Verdict uses the count including this final sample.
                    state_d            = DONE;
                    vec_d              = 2'd0;
                    {drv_a_d, drv_b_d} = 2'b00;
                    busy_d             = 1'b0;
                    done_d             = 1'b1;
                    pass_d             = (err_d == '0);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            vec_q   <= 2'd0;
            drv_a_q <= 1'b0;
            drv_b_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            pass_q  <= 1'b0;
`ifdef AND2_SEQ_ERRLOG_EN
            fev_q   <= 1'b0;
            fei_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            vec_q   <= vec_d;
            drv_a_q <= drv_a_d;
            drv_b_q <= drv_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
`ifdef AND2_SEQ_ERRLOG_EN
            fev_q   <= fev_d;
            fei_q   <= fei_d;
`endif
        end
    end

    assign sif.drv_a   = drv_a_q;
    assign sif.drv_b   = drv_b_q;
    assign sif.vec_idx = vec_q;
    assign sif.busy    = busy_q;
    assign sif.done    = done_q;
    assign sif.err_cnt = err_q;
    assign sif.pass    = pass_q;
`ifdef AND2_SEQ_ERRLOG_EN
    assign sif.first_err_vld = fev_q;
    assign sif.first_err_idx = fei_q;
`endif
endmodule

// File: doc/and2_seq_ctrl.md
# and2_seq_ctrl

Self-checking sequencer for the two-input AND gate cell (`and2`, ports `a`, `b`, `c`). On a start request it drives the gate through all four input combinations in a fixed order and holds each vector for a programmable settle time. It then samples the gate output, compares it against the expected AND value, counts mismatches and reports pass/fail with a one-cycle done pulse. It sits between a bench or BIST controller and a single `and2` instance, replacing hand-written `#delay` stimulus with a clocked, repeatable sequence.

## Interface
- `SETTLE_CYCLES`, default 3: cycles each vector is held before sampling; legal range ≥1.
- `CNT_W`, default 8: width of the mismatch counter.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `gate_out`  in  1  from the `and2` output `c`.
- `drv_a`  out  1  to `and2` input `a`.
- `drv_b`  out  1  to `and2` input `b`.
- `vec_idx`  out  2  index of the vector currently applied (0..3).
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse at end of run.
- `err_cnt`  out  CNT_W  saturating mismatch count of the last or current run.
- `pass`  out  1  high from DONE until the next accepted start, only if `err_cnt`==0.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. Reset value is IDLE, with `drv_a`=`drv_b`=0, `vec_idx`=0, `busy`=0, `done`=0, `err_cnt`=0 and `pass`=0.
- Vector order by `vec_idx` as {a,b}: 0→00, 1→10, 2→11, 3→01. This is Gray order, so one input changes per step.
- IDLE with `start`=1 is the accepting edge E0. It clears `err_cnt` and `pass`, sets `vec_idx`=0 with drive 00, resets the settle timer to 0 and moves to SETTLE.
- SETTLE increments the timer each edge. When the timer equals SETTLE_CYCLES-1, the next state is SAMPLE.
- SAMPLE compares at its edge. A mismatch is `gate_out` not equal to `drv_a & drv_b`; X/Z also counts as a mismatch and is compared with case-inequality.
  - On a mismatch, `err_cnt` increments and saturates at 2^CNT_W-1.
  - If `vec_idx`<3, `vec_idx` increments, the drive takes the next vector, the timer clears and the state returns to SETTLE.
  - If `vec_idx`==3, the state goes to DONE.
- DONE lasts exactly one cycle. In it, `done`=1, `busy`=0, the drive returns to 00, `vec_idx`=0 and `pass` is set if `err_cnt`==0. The next state is IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE. It is not queued.
- Reset asserted mid-run forces every output to its reset value immediately, without waiting for a clock edge. The partial result is discarded.

## Timing
- Each vector is driven for SETTLE_CYCLES+1 cycles: SETTLE_CYCLES cycles in SETTLE plus 1 cycle in SAMPLE.
- Vector k is sampled at edge E0+(k+1)·(SETTLE_CYCLES+1).
- `done` is high during the cycle following edge E0+4·(SETTLE_CYCLES+1). With the default setting that is edge E0+16.
- `err_cnt` updates at the SAMPLE edge and is visible in the next cycle. The final count is stable when `done`=1.
- The earliest restart is a `start` sampled in the cycle after `done`, i.e. in IDLE.
- All outputs are registered, and `drv_a`/`drv_b` change only on clock edges.

## Configuration
- `AND2_SEQ_ERRLOG_EN`
  - Defined: adds outputs `first_err_vld` (1 bit) and `first_err_idx` (2 bits). On the first mismatch of a run, `first_err_vld` is set to 1 and `first_err_idx` latches `vec_idx`; later mismatches leave both unchanged. Both clear on accepted start and on reset.
  - Undefined: these ports and registers do not exist. All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `start`=1 → every output is 0 and no run starts until `rst_n`=1.
- Good gate, SETTLE_CYCLES=3, one-cycle `start` → drive sequence 00,10,11,01 with each vector held 4 cycles. `done` pulses at E0+16, `err_cnt`=0, `pass`=1, and `busy` is high for exactly 16 cycles.
- Faulty gate modelled as OR → mismatches at vec 1 and 3, giving `err_cnt`=2 and `pass`=0. With `AND2_SEQ_ERRLOG_EN`: `first_err_vld`=1 and `first_err_idx`=1.
- Reset pulse while `vec_idx`=2 → outputs drop to 0 immediately. A new `start` then runs a full clean sequence with `err_cnt`=0.
- `start` held high continuously → a new run begins every 18 cycles (16 busy + DONE + IDLE). Pulses of `start` during `busy` or DONE are ignored, so the run length is unchanged.
- CNT_W=1 with the gate output stuck at 1 → 3 mismatches, and `err_cnt` saturates at 1 without wrapping; `pass`=0.
